// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a small valid/ready output FIFO.
// Reports framing errors and overruns as single-cycle pulses.
module uart_rx_fifo #(
    parameter int UART_CLK_HZ     = 100800000,
    parameter int UART_SCLK_HZ    = 115200,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int DIV   = UART_CLK_HZ / UART_SCLK_HZ;
    localparam int HALF  = DIV / 2;
    localparam int CW    = $clog2(DIV);
    localparam int AW    = FIFO_DEPTH_BITS;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

    logic [1:0]    r_sync;
    logic          w_rxs;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shreg;
    logic          r_push;
    logic [7:0]    r_push_data;
    logic          r_frame_err;

    logic [7:0]    r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_overrun;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [AW:0]   w_rptr_n;
    logic [AW:0]   w_wptr_n;
    logic [7:0]    w_head;

    assign w_rxs = r_sync[1];

    // Two-flop synchronizer; resets to idle-high so reset does not fake a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], uart_rxd};
    end

    // Receive FSM: mid-bit sampling timed from each start edge, stop check, error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shreg     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == CW'(HALF - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= w_rxs ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CW'(DIV - 1)) begin
                        r_cnt   <= '0;
                        r_shreg <= {w_rxs, r_shreg[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CW'(DIV - 1)) begin
                        r_cnt       <= '0;
                        r_push      <= w_rxs;
                        r_push_data <= r_shreg;
                        r_frame_err <= !w_rxs;
                        r_state     <= w_rxs ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rxs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop    = r_valid && rx_ready;
    assign w_push   = r_push && (!w_full || w_pop);
    assign w_rptr_n = r_rptr + (AW+1)'(w_pop);
    assign w_wptr_n = r_wptr + (AW+1)'(w_push);
    assign w_head   = (w_rptr_n == r_wptr) ? r_push_data : r_mem[w_rptr_n[AW-1:0]];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= r_push_data;
    end

    // Pointers, registered head/valid and overrun pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_wptr    <= w_wptr_n;
            r_rptr    <= w_rptr_n;
            r_data    <= w_head;
            r_valid   <= w_rptr_n != w_wptr_n;
            r_overrun <= r_push && !w_push;
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
endmodule
